conv_mem_responder: RTL

Memory-side responder for the convolution/max-pool engine's SRAM interface. It holds the 4096-word input image, the 4096-word layer-0 (conv+ReLU) result and the 1024-word layer-1 (max-pool) result. It answers the engine's image, write, read and `csel` strobes with zero-latency reads and edge-committed writes. A host port preloads the image, kicks the engine through `ready`/`busy`, and streams both result layers back out over a valid/ready channel.

---
 rtl/conv_mem_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_mem_responder.sv
// conv_mem_responder: SRAM-side responder for the conv/max-pool engine.
// Holds the input image, the layer-0 result and the layer-1 result. The engine
// gets zero-latency reads and edge-committed writes. A host port loads the image,
// kicks the engine, and streams both result layers out over valid/ready.
// Optional build macro: CONV_MEM_CHECK_EN compiles in the sticky protocol checker
// that drives err. Without it, err is tied to 0.
module conv_mem_responder #(
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned L1_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic [2:0]        csel,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [DATA_W-1:0] dp_data,
    output logic              dp_layer,
    output logic              dp_last,
    output logic              done,
    output logic              err
);

    localparam int unsigned IMG_DEPTH = 1 << ADDR_W;
    localparam int unsigned L1_AW     = $clog2(L1_DEPTH);

    localparam logic [2:0]        CSEL_L0  = 3'b001;
    localparam logic [2:0]        CSEL_L1  = 3'b011;
    localparam logic [ADDR_W-1:0] LAST_IMG = ADDR_W'(IMG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_L1  = ADDR_W'(L1_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_A   = '0;
    localparam logic [L1_AW-1:0]  ZERO_L1  = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_RUN,
        S_DUMP0,
        S_DUMP1,
        S_DONE
    } state_t;

    logic [DATA_W-1:0] img_mem [IMG_DEPTH];
    logic [DATA_W-1:0] l0_mem  [IMG_DEPTH];
    logic [DATA_W-1:0] l1_mem  [L1_DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              seen_busy;
    logic              load_fire;

    assign addr_nxt  = addr + ADDR_W'(1);
    assign load_fire = (state == S_LOAD) && ld_valid && ld_ready;

    // Engine image read, combinational.
    assign idata = img_mem[iaddr];

    // Engine result read: combinational, zero when no bank is selected or no strobe.
    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (csel == CSEL_L0) begin
                cdata_rd = l0_mem[caddr_rd];
            end else if (csel == CSEL_L1) begin
                cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
            end
        end
    end

    // Memory writes: host image load and engine result writes. Arrays are never reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            img_mem[addr] <= ld_data;
        end
        if (cwr && (csel == CSEL_L0)) begin
            l0_mem[caddr_wr] <= cdata_wr;
        end
        if (cwr && (csel == CSEL_L1)) begin
            l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        end
    end

    // Host session FSM with registered handshake and dump outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            seen_busy <= 1'b0;
            ready     <= 1'b0;
            ld_ready  <= 1'b0;
            dp_valid  <= 1'b0;
            dp_data   <= '0;
            dp_layer  <= 1'b0;
            dp_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        addr     <= '0;
                        done     <= 1'b0;
                        ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        addr <= addr_nxt;
                        if (addr == LAST_IMG) begin
                            ld_ready <= 1'b0;
                            ready    <= 1'b1;
                            state    <= S_KICK;
                        end
                    end
                end
                S_KICK: begin
                    seen_busy <= 1'b0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state    <= S_DUMP0;
                        addr     <= '0;
                        dp_valid <= 1'b1;
                        dp_layer <= 1'b0;
                        dp_last  <= 1'b0;
                        dp_data  <= l0_mem[ZERO_A];
                    end
                end
                S_DUMP0: begin
                    if (dp_ready) begin
                        if (addr == LAST_IMG) begin
                            addr     <= '0;
                            state    <= S_DUMP1;
                            dp_layer <= 1'b1;
                            dp_last  <= (LAST_L1 == ZERO_A);
                            dp_data  <= l1_mem[ZERO_L1];
                        end else begin
                            addr    <= addr_nxt;
                            dp_data <= l0_mem[addr_nxt];
                        end
                    end
                end
                S_DUMP1: begin
                    if (dp_ready) begin
                        if (addr == LAST_L1) begin
                            state    <= S_DONE;
                            dp_valid <= 1'b0;
                            dp_last  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            addr    <= addr_nxt;
                            dp_data <= l1_mem[addr_nxt[L1_AW-1:0]];
                            dp_last <= (addr_nxt == LAST_L1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONV_MEM_CHECK_EN
    logic wr_sel_ok;
    logic rd_sel_ok;
    logic err_set;

    assign wr_sel_ok = (csel == CSEL_L0) || (csel == CSEL_L1);
    assign rd_sel_ok = wr_sel_ok;

    // Any engine protocol violation seen at this edge.
    always_comb begin
        err_set = 1'b0;
        if (cwr && !wr_sel_ok)                                        err_set = 1'b1;
        if (crd && !rd_sel_ok)                                        err_set = 1'b1;
        if (cwr && crd)                                               err_set = 1'b1;
        if (cwr && (csel == CSEL_L1) && (|caddr_wr[ADDR_W-1:L1_AW]))  err_set = 1'b1;
        if (crd && (csel == CSEL_L1) && (|caddr_rd[ADDR_W-1:L1_AW]))  err_set = 1'b1;
        if (cwr && ((state == S_LOAD) || (state == S_DUMP0) || (state == S_DUMP1)))
            err_set = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
